// File: rtl/uart_rx_deserializer_if.sv
// Receive-side bundle between the UART deserializer and its environment.
// master: the deserializer (drives the FIFO write side and status pulses).
// slave:  the line/FIFO side (drives RX, Enable_rx and Full).
interface uart_rx_deserializer_if #(
    parameter int unsigned DataBits = 8
);
    logic                RX;
    logic                Enable_rx;
    logic                Full;
    logic [DataBits-1:0] RX_data;
    logic                RX_valid;
    logic                Frame_err;
    logic                Parity_err;
    logic                Overrun;
    logic                Busy;

    modport master (
        input  RX, Enable_rx, Full,
        output RX_data, RX_valid, Frame_err, Parity_err, Overrun, Busy
    );

    modport slave (
        output RX, Enable_rx, Full,
        input  RX_data, RX_valid, Frame_err, Parity_err, Overrun, Busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises RX, frames it and de-serialises into a word.
// Emits a one-cycle FIFO write strobe, or one error pulse, per frame.
module uart_rx_deserializer #(
    parameter int unsigned C_BAUDRATE    = 115_200,
    parameter int unsigned C_SYSTEM_FREQ = 50_000_000,
    parameter int unsigned C_DATA_BITS   = 8,
    parameter int unsigned C_USE_PARITY  = 0,
    parameter int unsigned C_ODD_PARITY  = 0
) (
    input logic                    Clk,
    input logic                    Reset,
    uart_rx_deserializer_if.master bus
);
    localparam int unsigned ClksPerBit = C_SYSTEM_FREQ / C_BAUDRATE;
    localparam int unsigned Half       = ClksPerBit / 2;
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned BitW       = $clog2(C_DATA_BITS + 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(C_DATA_BITS - 1);
    localparam logic            OddBit  = (C_ODD_PARITY != 0);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitIdle
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [C_DATA_BITS-1:0] shift_q, shift_d;
    logic [C_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                   par_err_q, par_err_d;
    logic                   valid_q, valid_d;
    logic                   frame_q, frame_d;
    logic                   parity_q, parity_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_meta_q, rx_s_q;

    // Two-flop synchroniser; idle-high reset so no false start after reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame state, timing counters and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            par_err_q <= par_err_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            parity_q  <= parity_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: half-bit start check, then one sample per bit period.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        par_err_d = par_err_q;
        valid_d   = 1'b0;
        frame_d   = 1'b0;
        parity_d  = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.Enable_rx && !rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        bit_d     = '0;
                        par_err_d = 1'b0;
                        state_d   = StData;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[C_DATA_BITS-1:1]};
                    if (bit_q == BitLast) begin
                        state_d = (C_USE_PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    par_err_d = (rx_s_q != ((^shift_q) ^ OddBit));
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    // Exactly one outcome per frame, framing error first.
                    if (!rx_s_q) begin
                        frame_d = 1'b1;
                        state_d = StWaitIdle;
                    end else if (par_err_q) begin
                        parity_d = 1'b1;
                        state_d  = StIdle;
                    end else if (bus.Full) begin
                        overrun_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        valid_d   = 1'b1;
                        rx_data_d = shift_q;
                        state_d   = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitIdle: begin
                // Swallow a break so it reports only one framing error.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.RX_data    = rx_data_q;
    assign bus.RX_valid   = valid_q;
    assign bus.Frame_err  = frame_q;
    assign bus.Parity_err = parity_q;
    assign bus.Overrun    = overrun_q;
    assign bus.Busy       = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench: an 8N1 receiver (dut_a) and an 8O1 receiver (dut_b) share one RX line.
module tb_uart_rx_deserializer;
    localparam int unsigned Cpb = 10;

    logic       Clk;
    logic       Reset;
    logic       rx_line;
    logic       en_a, en_b, full;
    int         total, bad;
    int         valid_a, frame_a, parity_a, over_a;
    int         valid_b, parity_b;
    int         s_valid_a, s_frame_a, s_parity_a, s_over_a, s_valid_b, s_parity_b;

    uart_rx_deserializer_if #(.DataBits(8)) bus_a ();
    uart_rx_deserializer_if #(.DataBits(8)) bus_b ();

    assign bus_a.RX        = rx_line;
    assign bus_a.Enable_rx = en_a;
    assign bus_a.Full      = full;
    assign bus_b.RX        = rx_line;
    assign bus_b.Enable_rx = en_b;
    assign bus_b.Full      = full;

    uart_rx_deserializer #(
        .C_BAUDRATE(100_000), .C_SYSTEM_FREQ(1_000_000), .C_DATA_BITS(8),
        .C_USE_PARITY(0), .C_ODD_PARITY(0)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a)
    );

    uart_rx_deserializer #(
        .C_BAUDRATE(100_000), .C_SYSTEM_FREQ(1_000_000), .C_DATA_BITS(8),
        .C_USE_PARITY(1), .C_ODD_PARITY(1)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count high cycles of each strobe, sampled away from the active edge.
    initial begin
        valid_a = 0; frame_a = 0; parity_a = 0; over_a = 0; valid_b = 0; parity_b = 0;
    end
    always @(negedge Clk) begin
        if (bus_a.RX_valid)   valid_a  = valid_a + 1;
        if (bus_a.Frame_err)  frame_a  = frame_a + 1;
        if (bus_a.Parity_err) parity_a = parity_a + 1;
        if (bus_a.Overrun)    over_a   = over_a + 1;
        if (bus_b.RX_valid)   valid_b  = valid_b + 1;
        if (bus_b.Parity_err) parity_b = parity_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid_a  = valid_a;
        s_frame_a  = frame_a;
        s_parity_a = parity_a;
        s_over_a   = over_a;
        s_valid_b  = valid_b;
        s_parity_b = parity_b;
    endtask

    task automatic bit_time(input logic b);
        rx_line = b;
        repeat (Cpb) @(negedge Clk);
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int par);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(data[i]);
        if (par >= 0) bit_time(par[0]);
        bit_time(stop_bit);
    endtask

    initial begin
        logic [7:0] d12;
        total = 0; bad = 0;
        Reset = 1'b1; rx_line = 1'b1; en_a = 1'b0; en_b = 1'b0; full = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_data", {24'h0, bus_a.RX_data}, 32'h00);
        check("reset_busy", {31'h0, bus_a.Busy}, 32'h0);
        check("reset_valid", {31'h0, bus_a.RX_valid}, 32'h0);
        Reset = 1'b0;
        en_a  = 1'b1;
        repeat (5) @(negedge Clk);

        // Back-to-back frames.
        snap();
        send_frame(8'hA5, 1'b1, -1);
        check("b2b_valid1", valid_a - s_valid_a, 1);
        check("b2b_data1", {24'h0, bus_a.RX_data}, 32'hA5);
        send_frame(8'h3C, 1'b1, -1);
        check("b2b_valid2", valid_a - s_valid_a, 2);
        check("b2b_data2", {24'h0, bus_a.RX_data}, 32'h3C);
        check("b2b_errs", (frame_a - s_frame_a) + (parity_a - s_parity_a) + (over_a - s_over_a), 0);
        check("b2b_busy", {31'h0, bus_a.Busy}, 32'h0);

        // Start-bit glitch.
        snap();
        rx_line = 1'b0;
        repeat (3) @(negedge Clk);
        rx_line = 1'b1;
        repeat (6) @(negedge Clk);
        check("glitch_busy", {31'h0, bus_a.Busy}, 32'h0);
        check("glitch_nopulse", (valid_a - s_valid_a) + (frame_a - s_frame_a), 0);
        send_frame(8'h01, 1'b1, -1);
        check("glitch_valid", valid_a - s_valid_a, 1);
        check("glitch_data", {24'h0, bus_a.RX_data}, 32'h01);

        // Framing error followed by a break.
        snap();
        send_frame(8'h3C, 1'b0, -1);
        repeat (30) @(negedge Clk);
        rx_line = 1'b1;
        repeat (5) @(negedge Clk);
        check("break_frame", frame_a - s_frame_a, 1);
        check("break_novalid", valid_a - s_valid_a, 0);
        send_frame(8'h81, 1'b1, -1);
        check("break_valid", valid_a - s_valid_a, 1);
        check("break_data", {24'h0, bus_a.RX_data}, 32'h81);
        check("break_frame_once", frame_a - s_frame_a, 1);

        // Overrun.
        send_frame(8'h55, 1'b1, -1);
        check("ovr_pre_data", {24'h0, bus_a.RX_data}, 32'h55);
        snap();
        full = 1'b1;
        send_frame(8'hAA, 1'b1, -1);
        check("ovr_pulse", over_a - s_over_a, 1);
        check("ovr_novalid", valid_a - s_valid_a, 0);
        check("ovr_hold", {24'h0, bus_a.RX_data}, 32'h55);
        full = 1'b0;

        // Odd parity on dut_b: 0x07 has three ones, so the parity bit is 0.
        en_a = 1'b0;
        en_b = 1'b1;
        repeat (5) @(negedge Clk);
        snap();
        send_frame(8'h07, 1'b1, 0);
        check("par_good_valid", valid_b - s_valid_b, 1);
        check("par_good_data", {24'h0, bus_b.RX_data}, 32'h07);
        check("par_good_noerr", parity_b - s_parity_b, 0);
        send_frame(8'h07, 1'b1, 1);
        check("par_bad_err", parity_b - s_parity_b, 1);
        check("par_bad_novalid", valid_b - s_valid_b, 1);
        check("par_a_ignored", valid_a - s_valid_a, 0);
        en_b = 1'b0;

        // Reset mid-frame, during data bit 4.
        en_a = 1'b1;
        d12  = 8'h12;
        snap();
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(d12[i]);
        rx_line = d12[4];
        repeat (5) @(negedge Clk);
        check("mid_busy_pre", {31'h0, bus_a.Busy}, 32'h1);
        Reset   = 1'b1;
        rx_line = 1'b1;
        en_a    = 1'b0;
        #1;
        check("rst_data", {24'h0, bus_a.RX_data}, 32'h00);
        check("rst_busy", {31'h0, bus_a.Busy}, 32'h0);
        check("rst_pulses", {27'h0, bus_a.RX_valid, bus_a.Frame_err, bus_a.Parity_err,
                             bus_a.Overrun, bus_b.Busy}, 32'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check("rst_nopulse", (valid_a - s_valid_a) + (frame_a - s_frame_a), 0);
        snap();
        send_frame(8'h12, 1'b1, -1);
        check("dis_ignored", valid_a - s_valid_a, 0);
        check("dis_busy", {31'h0, bus_a.Busy}, 32'h0);
        en_a = 1'b1;
        repeat (3) @(negedge Clk);
        send_frame(8'h12, 1'b1, -1);
        check("en_valid", valid_a - s_valid_a, 1);
        check("en_data", {24'h0, bus_a.RX_data}, 32'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
